array_stream_reader: RTL

//  Read-side engine for a 32-entry array2-style storage array (index_out/dataout port).
//  On a start command it walks a circular window of entries (base, count) and streams them

---
 rtl/array_stream_reader_pkg.sv | 18 +
 rtl/array_stream_reader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/array_stream_reader_pkg.sv
// Shared types and defaults for the array stream reader.
package array_stream_reader_pkg;

  // Default geometry of the attached storage array.
  localparam int ARS_DEF_WIDTH  = 16;
  localparam int ARS_DEF_HEIGHT = 32;

  // Command sequencing states.
  //   ARS_IDLE  : waiting for a start command
  //   ARS_READ  : walking the window, capturing one entry per free output slot
  //   ARS_DRAIN : every entry captured, waiting for the final beat to be accepted
  typedef enum logic [1:0] {
    ARS_IDLE  = 2'd0,
    ARS_READ  = 2'd1,
    ARS_DRAIN = 2'd2
  } ars_state_t;

endpackage

// File: rtl/array_stream_reader.sv
// Read-side engine for an array2-style storage array. On a start command it
// walks a circular window (base, count) of array entries and streams them out
// over a valid/ready handshake, one entry per cycle while downstream keeps up.
//
// Output handshake: a beat is transferred on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// beat (out_data/out_index/out_last) is held unchanged. out_valid never drops
// without an accepted beat, except on abort or reset.
module array_stream_reader
  import array_stream_reader_pkg::*;
#(
  parameter  int width  = ARS_DEF_WIDTH,
  parameter  int height = ARS_DEF_HEIGHT,
  localparam int IDX_W  = $clog2(height)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [IDX_W-1:0] base,
  input  logic [IDX_W:0]   count,
  input  logic             abort,
  output logic [IDX_W-1:0] arr_index,
  input  logic [width-1:0] arr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output ars_state_t       dbg_state
);

  ars_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   remaining;

  // The output slot can take a new entry when it is empty or being emptied now.
  logic             slot_free;
  logic             beat_accepted;
  logic             last_pending;

  assign slot_free     = !out_valid || out_ready;
  assign beat_accepted = out_valid && out_ready;
  assign last_pending  = (remaining == (IDX_W+1)'(1));

  // The array is read combinationally at the registered pointer, so the entry
  // presented on arr_data is the one captured at the next edge.
  assign arr_index = ptr;
  assign busy      = (state != ARS_IDLE);
  assign dbg_state = state;

  // Command FSM plus output register stage; abort overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARS_IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // Drop any in-flight beat and return quietly: no done pulse.
      state     <= ARS_IDLE;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ARS_IDLE: begin
          if (start) begin
            if (count != '0) begin
              ptr       <= base;
              remaining <= count;
              state     <= ARS_READ;
            end else begin
              // Empty window completes immediately without any beats.
              done <= 1'b1;
            end
          end
        end

        ARS_READ: begin
          if (slot_free) begin
            // Capture replaces (or fills) the slot; an accepted beat in the
            // same cycle is thereby retired with no bubble.
            out_data  <= arr_data;
            out_index <= ptr;
            out_last  <= last_pending;
            out_valid <= 1'b1;
            ptr       <= ptr + IDX_W'(1);
            remaining <= remaining - (IDX_W+1)'(1);
            if (last_pending) begin
              state <= ARS_DRAIN;
            end
          end
        end

        ARS_DRAIN: begin
          // The slot holds the final beat; finish once it is taken.
          if (beat_accepted) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= ARS_IDLE;
            end
          end
        end

        default: begin
          state     <= ARS_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
